mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single processor-memory port between the load/store queue (data side) and the instruction cache (fetch side). Each cycle it picks one requester, forwards that request to memory and returns memory's accept/tag response to the winner only. It keeps a tag-ownership table so that data memory returns later, tagged, reaches the requester that issued the load. It sits between the LSQ/icache pair and the memory bus model.

Parameters:
NUM_TAGS, 15, number of nonzero memory transaction tags (tag 0 means no tag / not accepted)
STARVE_LIMIT, 4, number of consecutive denied icache request cycles before icache gets priority
CNT_W, 4, width of the outstanding-transaction counters

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
lsq2arb_command  in  2  BUS_NONE / BUS_LOAD / BUS_STORE from LSQ
lsq2arb_addr  in  64  LSQ address
lsq2arb_data  in  64  LSQ store data
icache2arb_command  in  2  BUS_NONE / BUS_LOAD from icache; BUS_STORE is treated as BUS_NONE
icache2arb_addr  in  64  fetch address
mem2arb_response  in  4  memory accept tag for this cycle's command, 0 = rejected
mem2arb_tag  in  4  tag of data returning this cycle, 0 = none
mem2arb_data  in  64  returning data
arb2mem_command  out  2  granted command
arb2mem_addr  out  64  granted address
arb2mem_data  out  64  granted store data (LSQ), 0 for icache
arb2lsq_response  out  4  mem2arb_response if LSQ granted, else 0
arb2icache_response  out  4  mem2arb_response if icache granted, else 0
arb2lsq_tag  out  4  mem2arb_tag if the tag is owned by LSQ, else 0
arb2icache_tag  out  4  mem2arb_tag if the tag is owned by icache, else 0
arb2req_data  out  64  mem2arb_data passthrough
lsq_outstanding  out  CNT_W  LSQ loads in flight
icache_outstanding  out  CNT_W  icache loads in flight
tag_table_full  out  1  all NUM_TAGS tags owned

Behaviour:
- Grant is combinational in the cycle of the request; response routing is combinational off mem2arb_response; there is no added latency.
- Default priority goes to LSQ. The icache wins when LSQ command is BUS_NONE, or when starve_cnt == STARVE_LIMIT.
- starve_cnt (registered): increments, saturating at STARVE_LIMIT, in each cycle the icache requests and is not granted. It clears to 0 in a cycle where the icache is granted and mem2arb_response != 0. It holds otherwise.
- No grant (both requests BUS_NONE): arb2mem_command = BUS_NONE; addr/data = 0; both responses are 0.
- Loser response is 0. The requester retries next cycle; the arbiter keeps no request state.
- Accepted load (granted BUS_LOAD, response t != 0): at the next edge, owner_valid[t] <= 1, owner_lsq[t] <= (winner == LSQ), and the winner's outstanding counter increments.
- Accepted store: no table entry, no counter change. Stores never return data.
- Return (mem2arb_tag t != 0, owner_valid[t] = 1): route t to the owner's tag output in the same cycle. At the edge, clear owner_valid[t] and decrement the owner's counter.
- Return on an unowned tag: both tag outputs are 0 and the table is unchanged. This is a protocol error; the bench flags it.
- Same-cycle return of tag t and new acceptance with tag t: the return is routed to the old owner, and the new allocation wins in the table. Counters apply both the decrement and the increment (net 0 if same owner).
- Simultaneous accept and return on different tags: both are applied independently.
- tag_table_full = AND of owner_valid. It is informational only; memory is the authority on acceptance.
- Counters never wrap; they are bounded by NUM_TAGS < 2^CNT_W.
- Reset (asynchronous, active-low) clears owner_valid, owner_lsq, starve_cnt and both counters immediately. Combinational outputs follow from the inputs with a cleared table, so any return during reset routes to nobody. Reset asserted mid-transaction discards all ownership.

Test Plan:
- LSQ BUS_LOAD addr 0x1000 and icache BUS_LOAD addr 0x2000 in the same cycle, response 3 -> arb2mem_addr = 0x1000, arb2lsq_response = 3, arb2icache_response = 0; lsq_outstanding = 1 next cycle.
- LSQ requests continuously and icache requests continuously, memory accepts all -> icache denied 4 cycles, granted on the 5th, starve_cnt back to 0 afterwards.
- LSQ load gets tag 5 and icache load gets tag 6; then mem2arb_tag = 6, data 0xDEAD -> arb2icache_tag = 6, arb2lsq_tag = 0, arb2req_data = 0xDEAD, icache_outstanding 1 -> 0.
- LSQ BUS_STORE addr 0x40 data 0x55, response 2 -> arb2mem_data = 0x55, no table entry; a later mem2arb_tag = 2 routes to nobody.
- Tag 7 owned by icache returns in the same cycle that an LSQ load is accepted with tag 7 -> arb2icache_tag = 7; next cycle owner_lsq[7] = 1, lsq_outstanding +1, icache_outstanding -1.
- Fill all 15 tags, then pulse reset low between clock edges -> outstanding counts and tag_table_full drop to 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one processor-memory port between the LSQ (data side)
// and the icache (fetch side). Grant and response routing are combinational; a
// registered tag-ownership table steers returning load data back to its issuer.
module mem_port_arbiter #(
  parameter int unsigned NUM_TAGS     = 15,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic             clk,
  input  logic             reset,

  input  logic [1:0]       lsq2arb_command,
  input  logic [63:0]      lsq2arb_addr,
  input  logic [63:0]      lsq2arb_data,

  input  logic [1:0]       icache2arb_command,
  input  logic [63:0]      icache2arb_addr,

  input  logic [3:0]       mem2arb_response,
  input  logic [3:0]       mem2arb_tag,
  input  logic [63:0]      mem2arb_data,

  output logic [1:0]       arb2mem_command,
  output logic [63:0]      arb2mem_addr,
  output logic [63:0]      arb2mem_data,

  output logic [3:0]       arb2lsq_response,
  output logic [3:0]       arb2icache_response,
  output logic [3:0]       arb2lsq_tag,
  output logic [3:0]       arb2icache_tag,
  output logic [63:0]      arb2req_data,

  output logic [CNT_W-1:0] lsq_outstanding,
  output logic [CNT_W-1:0] icache_outstanding,
  output logic             tag_table_full
);

  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_LOAD  = 2'h1;
  localparam logic [1:0] BUS_STORE = 2'h2;

  localparam int unsigned         STARVE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [3:0]          MAX_TAG    = 4'(NUM_TAGS);

  // Ownership table, indexed directly by tag; entry 0 is never allocated.
  logic [NUM_TAGS:0]   owner_valid_q, owner_valid_d;
  logic [NUM_TAGS:0]   owner_lsq_q, owner_lsq_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [CNT_W-1:0]    lsq_cnt_q, lsq_cnt_d;
  logic [CNT_W-1:0]    icache_cnt_q, icache_cnt_d;

  logic lsq_req, icache_req;
  logic lsq_grant, icache_grant;
  logic acc_valid;
  logic ret_hit, ret_lsq;

  // Request decode and priority: LSQ by default, icache when LSQ idle or starved out.
  always_comb begin
    lsq_req      = (lsq2arb_command == BUS_LOAD) || (lsq2arb_command == BUS_STORE);
    // An icache store is meaningless and is ignored.
    icache_req   = (icache2arb_command == BUS_LOAD);
    icache_grant = icache_req && (!lsq_req || (starve_q == STARVE_MAX));
    lsq_grant    = lsq_req && !icache_grant;
  end

  // Forward the winner to memory and hand memory's response to the winner only.
  always_comb begin
    arb2mem_command     = BUS_NONE;
    arb2mem_addr        = '0;
    arb2mem_data        = '0;
    arb2lsq_response    = '0;
    arb2icache_response = '0;
    if (lsq_grant) begin
      arb2mem_command  = lsq2arb_command;
      arb2mem_addr     = lsq2arb_addr;
      arb2mem_data     = lsq2arb_data;
      arb2lsq_response = mem2arb_response;
    end else if (icache_grant) begin
      arb2mem_command     = BUS_LOAD;
      arb2mem_addr        = icache2arb_addr;
      arb2icache_response = mem2arb_response;
    end
  end

  // Route returning data to the current owner of its tag; unowned tags go nowhere.
  always_comb begin
    ret_hit        = (mem2arb_tag != 4'd0) && (mem2arb_tag <= MAX_TAG) &&
                     owner_valid_q[mem2arb_tag];
    ret_lsq        = owner_lsq_q[mem2arb_tag];
    arb2lsq_tag    = (ret_hit && ret_lsq)  ? mem2arb_tag : 4'd0;
    arb2icache_tag = (ret_hit && !ret_lsq) ? mem2arb_tag : 4'd0;
    arb2req_data   = mem2arb_data;
  end

  // Next table/counter/starvation state; a same-tag return+accept lets the new owner win.
  always_comb begin
    acc_valid = (mem2arb_response != 4'd0) && (mem2arb_response <= MAX_TAG) &&
                ((lsq_grant && (lsq2arb_command == BUS_LOAD)) || icache_grant);

    owner_valid_d = owner_valid_q;
    owner_lsq_d   = owner_lsq_q;
    if (ret_hit) begin
      owner_valid_d[mem2arb_tag] = 1'b0;
    end
    if (acc_valid) begin
      owner_valid_d[mem2arb_response] = 1'b1;
      owner_lsq_d[mem2arb_response]   = lsq_grant;
    end

    lsq_cnt_d    = lsq_cnt_q + CNT_W'(acc_valid && lsq_grant)
                             - CNT_W'(ret_hit && ret_lsq);
    icache_cnt_d = icache_cnt_q + CNT_W'(acc_valid && icache_grant)
                                - CNT_W'(ret_hit && !ret_lsq);

    starve_d = starve_q;
    if (icache_req && !icache_grant) begin
      if (starve_q != STARVE_MAX) begin
        starve_d = starve_q + STARVE_W'(1);
      end
    end else if (icache_grant && (mem2arb_response != 4'd0)) begin
      starve_d = '0;
    end
  end

  // State registers; reset discards all ownership immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_valid_q <= '0;
      owner_lsq_q   <= '0;
      starve_q      <= '0;
      lsq_cnt_q     <= '0;
      icache_cnt_q  <= '0;
    end else begin
      owner_valid_q <= owner_valid_d;
      owner_lsq_q   <= owner_lsq_d;
      starve_q      <= starve_d;
      lsq_cnt_q     <= lsq_cnt_d;
      icache_cnt_q  <= icache_cnt_d;
    end
  end

  // Status outputs straight from state.
  always_comb begin
    lsq_outstanding    = lsq_cnt_q;
    icache_outstanding = icache_cnt_q;
    tag_table_full     = &owner_valid_q[NUM_TAGS:1];
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run, all checked against a tag-owner map model.
module tb_mem_port_arbiter;

  localparam int NT = 15;
  localparam int SL = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    lsq2arb_command, icache2arb_command;
  logic [63:0]   lsq2arb_addr, lsq2arb_data, icache2arb_addr, mem2arb_data;
  logic [3:0]    mem2arb_response, mem2arb_tag;
  logic [1:0]    arb2mem_command;
  logic [63:0]   arb2mem_addr, arb2mem_data, arb2req_data;
  logic [3:0]    arb2lsq_response, arb2icache_response, arb2lsq_tag, arb2icache_tag;
  logic [CW-1:0] lsq_outstanding, icache_outstanding;
  logic          tag_table_full;

  mem_port_arbiter #(.NUM_TAGS(NT), .STARVE_LIMIT(SL), .CNT_W(CW)) dut (
    .clk                 (clk),
    .reset               (reset),
    .lsq2arb_command     (lsq2arb_command),
    .lsq2arb_addr        (lsq2arb_addr),
    .lsq2arb_data        (lsq2arb_data),
    .icache2arb_command  (icache2arb_command),
    .icache2arb_addr     (icache2arb_addr),
    .mem2arb_response    (mem2arb_response),
    .mem2arb_tag         (mem2arb_tag),
    .mem2arb_data        (mem2arb_data),
    .arb2mem_command     (arb2mem_command),
    .arb2mem_addr        (arb2mem_addr),
    .arb2mem_data        (arb2mem_data),
    .arb2lsq_response    (arb2lsq_response),
    .arb2icache_response (arb2icache_response),
    .arb2lsq_tag         (arb2lsq_tag),
    .arb2icache_tag      (arb2icache_tag),
    .arb2req_data        (arb2req_data),
    .lsq_outstanding     (lsq_outstanding),
    .icache_outstanding  (icache_outstanding),
    .tag_table_full      (tag_table_full)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: owner[t] = 0 free, 1 LSQ, 2 icache; starve = consecutive denied icache cycles.
  int owner[16];
  int starve;
  int p_ret, p_acc, p_acc_owner, p_starve;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic int count_owned(input int who);
    int n = 0;
    for (int t = 1; t <= NT; t++) if (owner[t] == who) n++;
    return n;
  endfunction

  function automatic int pick_free(input int rt);
    int cand[$];
    for (int t = 1; t <= NT; t++) if (owner[t] == 0 || t == rt) cand.push_back(t);
    if (cand.size() == 0) return 0;
    return cand[$urandom_range(cand.size() - 1)];
  endfunction

  function automatic int pick_owned();
    int cand[$];
    for (int t = 1; t <= NT; t++) if (owner[t] != 0) cand.push_back(t);
    if (cand.size() == 0) return 0;
    return cand[$urandom_range(cand.size() - 1)];
  endfunction

  task automatic chk_state(input string name);
    chk({name, "_lsq_out"}, 64'(lsq_outstanding), 64'(count_owned(1)));
    chk({name, "_ic_out"}, 64'(icache_outstanding), 64'(count_owned(2)));
    chk({name, "_full"}, 64'(tag_table_full), 64'(count_owned(0) == 0));
  endtask

  // Apply one cycle's inputs and check all combinational outputs against the model.
  task automatic drive(input logic [1:0] lc, input logic [63:0] la, input logic [63:0] ld,
                       input logic [1:0] ic, input logic [63:0] ia, input logic [3:0] resp,
                       input logic [3:0] rt, input logic [63:0] rd);
    bit lreq, ireq, lwin, iwin;
    logic [1:0] e_cmd;
    logic [63:0] e_addr, e_data;
    lsq2arb_command = lc; lsq2arb_addr = la; lsq2arb_data = ld;
    icache2arb_command = ic; icache2arb_addr = ia;
    mem2arb_response = resp; mem2arb_tag = rt; mem2arb_data = rd;
    #1;
    lreq = (lc == 2'd1) || (lc == 2'd2);
    ireq = (ic == 2'd1);
    iwin = ireq && (!lreq || starve == SL);
    lwin = lreq && !iwin;
    e_cmd  = lwin ? lc : (iwin ? 2'd1 : 2'd0);
    e_addr = lwin ? la : (iwin ? ia : 64'd0);
    e_data = lwin ? ld : 64'd0;
    chk("cmd", 64'(arb2mem_command), 64'(e_cmd));
    chk("addr", arb2mem_addr, e_addr);
    chk("data", arb2mem_data, e_data);
    chk("lsq_resp", 64'(arb2lsq_response), lwin ? 64'(resp) : 64'd0);
    chk("ic_resp", 64'(arb2icache_response), iwin ? 64'(resp) : 64'd0);
    chk("lsq_tag", 64'(arb2lsq_tag), (rt != 0 && owner[rt] == 1) ? 64'(rt) : 64'd0);
    chk("ic_tag", 64'(arb2icache_tag), (rt != 0 && owner[rt] == 2) ? 64'(rt) : 64'd0);
    chk("req_data", arb2req_data, rd);
    p_ret = (rt != 0 && owner[rt] != 0) ? int'(rt) : 0;
    p_acc = (resp != 0 && ((lwin && lc == 2'd1) || iwin)) ? int'(resp) : 0;
    p_acc_owner = lwin ? 1 : 2;
    p_starve = starve;
    if (ireq && !iwin) p_starve = (starve < SL) ? starve + 1 : SL;
    else if (iwin && resp != 0) p_starve = 0;
  endtask

  // Clock edge: commit the model and check the registered outputs.
  task automatic tick(input string name);
    @(posedge clk);
    if (p_ret != 0) owner[p_ret] = 0;
    if (p_acc != 0) owner[p_acc] = p_acc_owner;
    starve = p_starve;
    #1;
    chk_state(name);
  endtask

  task automatic step(input logic [1:0] lc, input logic [63:0] la, input logic [63:0] ld,
                      input logic [1:0] ic, input logic [63:0] ia, input logic [3:0] resp,
                      input logic [3:0] rt, input logic [63:0] rd);
    drive(lc, la, ld, ic, ia, resp, rt, rd);
    tick("step");
  endtask

  // Pulse reset between edges; the table must clear without a clock.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    for (int t = 0; t < 16; t++) owner[t] = 0;
    starve = 0;
    chk_state("reset_async");
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [1:0] lc, ic;
    logic [3:0] rt, resp;
    reset = 1'b0;
    lsq2arb_command = 2'd0; lsq2arb_addr = '0; lsq2arb_data = '0;
    icache2arb_command = 2'd0; icache2arb_addr = '0;
    mem2arb_response = '0; mem2arb_tag = '0; mem2arb_data = '0;
    for (int t = 0; t < 16; t++) owner[t] = 0;
    starve = 0;
    #12;
    chk_state("reset");
    chk("reset_cmd", 64'(arb2mem_command), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Simultaneous loads: LSQ wins, gets tag 3.
    drive(2'd1, 64'h1000, 64'd0, 2'd1, 64'h2000, 4'd3, 4'd0, 64'd0);
    chk("t1_addr", arb2mem_addr, 64'h1000);
    chk("t1_lsq_resp", 64'(arb2lsq_response), 64'd3);
    chk("t1_ic_resp", 64'(arb2icache_response), 64'd0);
    tick("t1");
    chk("t1_lsq_out", 64'(lsq_outstanding), 64'd1);

    // Starvation: icache denied four cycles, granted on the fifth.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(2'd1, 64'h100 + 64'(i), 64'd0, 2'd1, 64'h900, 4'(i + 1), 4'd0, 64'd0);
      chk("t2_denied", 64'(arb2icache_response), 64'd0);
      tick("t2");
    end
    drive(2'd1, 64'h104, 64'd0, 2'd1, 64'h900, 4'd5, 4'd0, 64'd0);
    chk("t2_granted_addr", arb2mem_addr, 64'h900);
    chk("t2_granted_resp", 64'(arb2icache_response), 64'd5);
    tick("t2g");
    drive(2'd1, 64'h105, 64'd0, 2'd1, 64'h900, 4'd6, 4'd0, 64'd0);
    chk("t2_lsq_again", arb2mem_addr, 64'h105);
    tick("t2a");

    // LSQ tag 5, icache tag 6, then tag 6 returns to icache.
    do_reset();
    step(2'd1, 64'h10, 64'd0, 2'd0, 64'd0, 4'd5, 4'd0, 64'd0);
    step(2'd0, 64'd0, 64'd0, 2'd1, 64'h20, 4'd6, 4'd0, 64'd0);
    chk("t3_ic_out1", 64'(icache_outstanding), 64'd1);
    drive(2'd0, 64'd0, 64'd0, 2'd0, 64'd0, 4'd0, 4'd6, 64'hDEAD);
    chk("t3_ic_tag", 64'(arb2icache_tag), 64'd6);
    chk("t3_lsq_tag", 64'(arb2lsq_tag), 64'd0);
    chk("t3_data", arb2req_data, 64'hDEAD);
    tick("t3");
    chk("t3_ic_out0", 64'(icache_outstanding), 64'd0);

    // Store accepted with tag 2 allocates nothing; a return on tag 2 goes nowhere.
    drive(2'd2, 64'h40, 64'h55, 2'd0, 64'd0, 4'd2, 4'd0, 64'd0);
    chk("t4_data", arb2mem_data, 64'h55);
    tick("t4");
    drive(2'd0, 64'd0, 64'd0, 2'd0, 64'd0, 4'd0, 4'd2, 64'h77);
    chk("t4_ret_lsq", 64'(arb2lsq_tag), 64'd0);
    chk("t4_ret_ic", 64'(arb2icache_tag), 64'd0);
    tick("t4r");

    // Tag 7 returns to icache while LSQ is accepted on tag 7.
    step(2'd0, 64'd0, 64'd0, 2'd1, 64'h70, 4'd7, 4'd0, 64'd0);
    drive(2'd1, 64'h80, 64'd0, 2'd0, 64'd0, 4'd7, 4'd7, 64'h1);
    chk("t5_ic_tag", 64'(arb2icache_tag), 64'd7);
    tick("t5");
    chk("t5_lsq_out", 64'(lsq_outstanding), 64'd2);
    chk("t5_ic_out", 64'(icache_outstanding), 64'd0);
    drive(2'd0, 64'd0, 64'd0, 2'd0, 64'd0, 4'd0, 4'd7, 64'h2);
    chk("t5_owner_lsq", 64'(arb2lsq_tag), 64'd7);
    tick("t5r");

    // Randomized traffic with a legal memory model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      lc = 2'($urandom_range(2));
      ic = 2'($urandom_range(2));
      rt = ($urandom_range(2) != 0) ? 4'(pick_owned()) : 4'd0;
      resp = ($urandom_range(3) != 0) ? 4'(pick_free(int'(rt))) : 4'd0;
      step(lc, {$urandom, $urandom}, {$urandom, $urandom}, ic, {$urandom, $urandom},
           resp, rt, {$urandom, $urandom});
      if (i == 300) do_reset();
    end

    // Fill all tags, then reset between edges.
    do_reset();
    for (int t = 1; t <= NT; t++) step(2'd1, 64'(t), 64'd0, 2'd0, 64'd0, 4'(t), 4'd0, 64'd0);
    chk("t6_full", 64'(tag_table_full), 64'd1);
    chk("t6_lsq_out", 64'(lsq_outstanding), 64'(NT));
    drive(2'd0, 64'd0, 64'd0, 2'd0, 64'd0, 4'd0, 4'd0, 64'd0);
    #2;
    reset = 1'b0;
    #1;
    for (int t = 0; t < 16; t++) owner[t] = 0;
    starve = 0;
    chk("t6_full_async", 64'(tag_table_full), 64'd0);
    chk("t6_lsq_async", 64'(lsq_outstanding), 64'd0);
    mem2arb_tag = 4'd3;
    #1;
    chk("t6_ret_nobody", 64'(arb2lsq_tag), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    mem2arb_tag = 4'd0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
